game_timer_ctrl: RTL and testbench
==================================

# game_timer_ctrl

Run controller for the game clock. It sequences start/pause/resume/stop of a centisecond-style game timer and divides CLOCK10M down to a programmable tick. It also compares the running count against a limit latched at start and flags expiry to the game logic. It sits between the player/control inputs and the score/display logic, which consume `count`, `tick` and `time_up`.

## Interface

Parameters:
- TICK_DIV, 100000, CLOCK10M cycles per count increment (100000 gives 10 ms); legal range ≥ 2.
- CNT_W, 10, width of `count` and `limit`.

Ports:
- CLOCK10M, in, 1, the only clock, rising-edge.
- KEY0, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle command: (re)start the timer from 0 and latch `limit`.
- pause, in, 1, single-cycle command: toggle RUNNING ↔ PAUSED.
- stop, in, 1, single-cycle command: return to IDLE and hold `count`.
- limit, in, CNT_W, expiry value; sampled only on an accepted `start`; 0 = no limit.
- count, out, CNT_W, elapsed ticks since the last start.
- tick, out, 1, one-cycle pulse, high in the cycle after each `count` increment edge.
- time_up, out, 1, one-cycle pulse on entering EXPIRED.
- state, out, 2, IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
- running, out, 1, high when `state` == RUNNING.

## Operation

- Internal registers:
  - Prescaler `pre`: range 0..TICK_DIV-1, width ceil(log2(TICK_DIV)).
  - Latched limit `lim_q`: CNT_W bits.
- Command priority when several are asserted on one edge: stop > start > pause.
- stop, from any state:
  - next state = IDLE; `pre` = 0; `count` holds.
  - Any tick due on that edge is suppressed: no increment, no `tick`, no `time_up`.
- start, from any state including RUNNING and PAUSED:
  - next state = RUNNING; `count` = 0; `pre` = 0; `lim_q` = `limit`.
  - Suppresses any tick due on that edge.
- pause:
  - RUNNING → PAUSED; PAUSED → RUNNING.
  - Ignored in IDLE and EXPIRED.
- Counting, only while the current state is RUNNING and no stop/start is accepted:
  - If `pre` < TICK_DIV-1: `pre` += 1.
  - Otherwise: `pre` = 0, `count` += 1, `tick` = 1.
- Pause and tick on the same edge (tick boundary reached together with `pause` in RUNNING): the increment happens and the state becomes PAUSED.
- PAUSED freezes both `pre` and `count`. Resume continues the sub-tick phase; it does not restart it.
- Expiry (when `lim_q` ≠ 0):
  - Condition: the incremented value equals `lim_q`.
  - On that edge: state → EXPIRED, `time_up` = 1.
  - `count` stays at `lim_q` until the next start, stop or reset.
- No limit (`lim_q` = 0): `count` wraps from 2^CNT_W−1 to 0 modulo 2^CNT_W; never expires.
- Limit below count: if `lim_q` ≠ 0 and `lim_q` < current count cannot occur, because count restarts from 0 at latch time.
- `limit` changes outside a start have no effect.

## Timing

- Reset (KEY0 high, asynchronous) applies immediately and holds while asserted:
  - state = IDLE, count = 0, tick = 0, time_up = 0, running = 0, `pre` = 0, `lim_q` = 0.
- Deassertion of KEY0 is clean: the first edge after release evaluates commands normally.
- All outputs are registered. No combinational path from inputs to outputs.
- Start latency:
  - start sampled at edge E → state = RUNNING and count = 0 after E.
  - Increment n lands at edge E + n·TICK_DIV, provided there are no pauses.
- Pause latency: `pause` at edge E freezes from E. Each paused cycle delays later increments by one cycle.
- `tick` and `time_up` are high for exactly one cycle, coincident with the new `count` value.
- Commands are level-sampled each edge. A command held for k cycles acts k times; `pause` held high toggles each cycle. Upstream supplies pulses.

## Test plan

All scenarios use TICK_DIV=4, CNT_W=4.

- Basic run to expiry:
  - Stimulus: reset, then start with limit=3 at edge E.
  - Response: count=1 at E+4, 2 at E+8, 3 at E+12 with time_up=1 for one cycle and state=3. Count stays 3 for 20 further cycles; tick stays 0.
- Pause preserves phase:
  - Stimulus: start (limit=0) at E; pause at E+6 (count=1, pre=2); hold paused 10 cycles; pause again at E+16.
  - Response: count=1 throughout the pause; count=2 at E+18.
- Free-run wrap:
  - Stimulus: start with limit=0.
  - Response: count=15 at E+60, count=0 at E+64 with tick=1, time_up=0, state=1.
- Stop on the expiry edge:
  - Stimulus: limit=2; assert stop at E+8.
  - Response: count stays 1, state=0, tick=0, time_up=0.
- Async reset mid-run:
  - Stimulus: assert KEY0 between edges at count=5.
  - Response: count=0, state=0, running=0 before the next edge. After release, start runs normally.
- Restart from PAUSED:
  - Stimulus: while PAUSED at count=7, assert start with limit=1 together with pause.
  - Response: start wins; count=0, state=1; expiry at 4 cycles later with count=1 and time_up=1.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// Game clock run controller: start/pause/stop sequencing, tick prescaler
// and limit-based expiry. All outputs come straight from registers.
module game_timer_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 10
) (
  input  logic             CLOCK10M,
  input  logic             KEY0,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             time_up,
  output logic [1:0]       state,
  output logic             running
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_lim, w_lim_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_time_up, w_time_up_nxt;

  always_ff @(posedge CLOCK10M or posedge KEY0) begin
    if (KEY0) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_tick    <= 1'b0;
      r_time_up <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lim     <= w_lim_nxt;
      r_tick    <= w_tick_nxt;
      r_time_up <= w_time_up_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre;
    w_cnt_nxt     = r_cnt;
    w_lim_nxt     = r_lim;
    w_tick_nxt    = 1'b0;
    w_time_up_nxt = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
    end else if (start) begin
      w_state_nxt = RUNNING;
      w_pre_nxt   = '0;
      w_cnt_nxt   = '0;
      w_lim_nxt   = limit;
    end else begin
      case (r_state)
        RUNNING: begin
          if (pause) w_state_nxt = PAUSED;
          if (r_pre == PRE_MAX) begin
            w_pre_nxt  = '0;
            w_cnt_nxt  = w_cnt_inc;
            w_tick_nxt = 1'b1;
            // Expiry outranks a coincident pause toggle.
            if (r_lim != '0 && w_cnt_inc == r_lim) begin
              w_state_nxt   = EXPIRED;
              w_time_up_nxt = 1'b1;
            end
          end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        PAUSED:  if (pause) w_state_nxt = RUNNING;
        default: ;
      endcase
    end
  end

  assign count   = r_cnt;
  assign tick    = r_tick;
  assign time_up = r_time_up;
  assign state   = r_state;
  assign running = (r_state == RUNNING);
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomized + directed bench for game_timer_ctrl against an elapsed-time model.
module tb_game_timer_ctrl;
  localparam int TD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 0, pause = 0, stop = 0;
  logic [CW-1:0] limit = '0;
  logic [CW-1:0] count;
  logic          tick, time_up, running;
  logic [1:0]    state;

  int n_cmp = 0, n_err = 0;

  game_timer_ctrl #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .CLOCK10M(clk), .KEY0(rst), .start(start), .pause(pause), .stop(stop),
    .limit(limit), .count(count), .tick(tick), .time_up(time_up),
    .state(state), .running(running)
  );

  always #5 clk = ~clk;

  // Model: count is simply elapsed running cycles / TD since the last start.
  int m_el, m_st, m_cnt, m_lim;
  bit m_tick, m_tu;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_el = 0; m_st = 0; m_cnt = 0; m_lim = 0; m_tick = 0; m_tu = 0;
    end else begin
      m_tick = 0; m_tu = 0;
      if (stop) m_st = 0;
      else if (start) begin m_st = 1; m_el = 0; m_cnt = 0; m_lim = int'(limit); end
      else if (m_st == 1) begin
        m_el++;
        if (pause) m_st = 2;
        if (m_el % TD == 0) begin
          m_tick = 1;
          m_cnt = (m_el / TD) % (1 << CW);
          if (m_lim != 0 && m_el / TD == m_lim) begin m_st = 3; m_tu = 1; end
        end
      end else if (m_st == 2 && pause) m_st = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (int'(count) != m_cnt || tick != m_tick || time_up != m_tu ||
          int'(state) != m_st || running != (m_st == 1)) begin
        n_err++;
        $display("FAIL model t=%0t: dut cnt=%0d tick=%0d tu=%0d st=%0d run=%0d, want cnt=%0d tick=%0d tu=%0d st=%0d",
                 $time, count, tick, time_up, state, running, m_cnt, m_tick, m_tu, m_st);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Pulse a start at the next edge; returns 2ns after that edge (edge E).
  task automatic do_start(input int lim);
    limit = CW'(lim); start = 1; cyc(); start = 0;
  endtask

  initial begin
    #3;
    chk("reset count", int'(count), 0);
    chk("reset state", int'(state), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset running", int'(running), 0);
    cyc(); rst = 0; cyc();

    // Run to expiry with limit 3
    do_start(3);
    chk("s1 state E", int'(state), 1);
    chk("s1 count E", int'(count), 0);
    cyc(4);  chk("s1 count E+4", int'(count), 1);
    cyc(4);  chk("s1 count E+8", int'(count), 2);
    cyc(4);  chk("s1 count E+12", int'(count), 3);
    chk("s1 time_up", int'(time_up), 1);
    chk("s1 state exp", int'(state), 3);
    cyc();   chk("s1 time_up one cycle", int'(time_up), 0);
    cyc(19); chk("s1 count hold", int'(count), 3);
    chk("s1 tick hold", int'(tick), 0);

    // Pause preserves sub-tick phase
    do_start(0);
    cyc(5); pause = 1; cyc(); pause = 0;
    chk("s2 paused state", int'(state), 2);
    chk("s2 paused count", int'(count), 1);
    cyc(9); chk("s2 count frozen", int'(count), 1);
    pause = 1; cyc(); pause = 0;
    chk("s2 resumed", int'(state), 1);
    cyc();  chk("s2 count E+17", int'(count), 1);
    cyc();  chk("s2 count E+18", int'(count), 2);
    chk("s2 tick E+18", int'(tick), 1);

    // Free-run wrap
    do_start(0);
    cyc(60); chk("s3 count 15", int'(count), 15);
    cyc(4);  chk("s3 wrap count", int'(count), 0);
    chk("s3 wrap tick", int'(tick), 1);
    chk("s3 wrap tu", int'(time_up), 0);
    chk("s3 wrap state", int'(state), 1);

    // Stop on the expiry edge
    do_start(2);
    cyc(7); stop = 1; cyc(); stop = 0;
    chk("s4 count", int'(count), 1);
    chk("s4 state", int'(state), 0);
    chk("s4 tick", int'(tick), 0);
    chk("s4 tu", int'(time_up), 0);

    // Async reset mid-run
    do_start(0);
    cyc(20); chk("s5 pre count", int'(count), 5);
    #1 rst = 1; #1;
    chk("s5 rst count", int'(count), 0);
    chk("s5 rst state", int'(state), 0);
    chk("s5 rst running", int'(running), 0);
    cyc(); rst = 0;
    do_start(0);
    cyc(4); chk("s5 after release", int'(count), 1);

    // Restart from PAUSED, start wins over pause
    do_start(0);
    cyc(27); pause = 1; cyc(); pause = 0;
    chk("s6 paused count", int'(count), 7);
    chk("s6 paused state", int'(state), 2);
    cyc(2);
    limit = 1; start = 1; pause = 1; cyc(); start = 0; pause = 0;
    chk("s6 restart count", int'(count), 0);
    chk("s6 restart state", int'(state), 1);
    cyc(3); chk("s6 not yet", int'(count), 0);
    cyc();  chk("s6 exp count", int'(count), 1);
    chk("s6 exp tu", int'(time_up), 1);
    chk("s6 exp state", int'(state), 3);

    // Random commands, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      limit = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1; #1 rst = 0;
      end
      cyc();
    end
    start = 0; pause = 0; stop = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
